// File: rtl/pixel_write_arbiter_if.sv
// pixel_write_arbiter_if
//
// Purpose: bundles the three drawing requesters' pixel handshake and the
// registered pixel write port towards vga_adapter into one connection.
//
// Signals (requester i occupies slice [i*W +: W] of each packed field):
//   req        3      per-requester request
//   last       3      final pixel of requester i's burst
//   x_in       3*XW   packed x coordinates
//   y_in       3*YW   packed y coordinates
//   col_in     3*CW   packed colours
//   gnt        3      one-hot grant; a pixel moves on every req[i] & gnt[i]
//   vga_x      XW     to vga_adapter x
//   vga_y      YW     to vga_adapter y
//   vga_colour CW     to vga_adapter colour
//   vga_plot   1      to vga_adapter plot
//
// Modports: master = drawing side plus VGA consumer, slave = the arbiter.
interface pixel_write_arbiter_if #(
  parameter int XW = 9,
  parameter int YW = 8,
  parameter int CW = 15
);
  logic [2:0]      req;
  logic [2:0]      last;
  logic [3*XW-1:0] x_in;
  logic [3*YW-1:0] y_in;
  logic [3*CW-1:0] col_in;
  logic [2:0]      gnt;
  logic [XW-1:0]   vga_x;
  logic [YW-1:0]   vga_y;
  logic [CW-1:0]   vga_colour;
  logic            vga_plot;

  modport master (
    output req, last, x_in, y_in, col_in,
    input  gnt, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  req, last, x_in, y_in, col_in,
    output gnt, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/pixel_write_arbiter.sv
// pixel_write_arbiter
//
// Purpose: shares the single pixel write port of the 320x240, 15-bit-colour
// vga_adapter among three drawing requesters (background/clear, target
// circle, cursor/score overlay). Whole bursts are granted round-robin and
// the winning pixel is registered onto the VGA write port one cycle after
// it transfers. Off-screen pixels complete their handshake but do not plot.
//
// Ports:
//   clk_i           system clock (CLOCK_50)
//   rst_ni          asynchronous active-low reset
//   bus             pixel_write_arbiter_if.slave: req/last/x_in/y_in/col_in
//                   in, gnt and vga_x/vga_y/vga_colour/vga_plot out
//   clear_start_i   single-cycle pulse requesting a full-screen clear
//   clear_colour_i  fill colour, sampled together with clear_start_i
//   clear_busy_o    clear pending or in progress
//
// Build option: define PIXEL_ARB_CLEAR_EN to compile in the full-screen
// clear engine (CLEAR state, pending flag, x/y walk counters). Without it
// clear_start_i/clear_colour_i are ignored and clear_busy_o is tied low.
module pixel_write_arbiter #(
  parameter int XW       = 9,
  parameter int YW       = 8,
  parameter int CW       = 15,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  pixel_write_arbiter_if.slave bus,
  input  logic                 clear_start_i,
  input  logic [CW-1:0]        clear_colour_i,
  output logic                 clear_busy_o
);

`ifdef PIXEL_ARB_CLEAR_EN
  typedef enum logic [1:0] {IDLE, BURST, CLEAR} state_t;
`else
  typedef enum logic {IDLE, BURST} state_t;
`endif

  localparam logic [XW-1:0] X_LIMIT = XW'(SCREEN_W);
  localparam logic [YW-1:0] Y_LIMIT = YW'(SCREEN_H);

  state_t        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [XW-1:0] vgaX_q, vgaX_d;
  logic [YW-1:0] vgaY_q, vgaY_d;
  logic [CW-1:0] vgaColour_q, vgaColour_d;
  logic          vgaPlot_q, vgaPlot_d;

  logic          selReq, selLast;
  logic [XW-1:0] selX;
  logic [YW-1:0] selY;
  logic [CW-1:0] selCol;
  logic          onScreen;
  logic [2:0]    gntVec;

`ifdef PIXEL_ARB_CLEAR_EN
  localparam logic [XW-1:0] LAST_X = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] LAST_Y = YW'(SCREEN_H - 1);

  logic          clearPending_q, clearPending_d;
  logic          clearDone_q, clearDone_d;
  logic [CW-1:0] clearColour_q, clearColour_d;
  logic [XW-1:0] clrX_q, clrX_d;
  logic [YW-1:0] clrY_q, clrY_d;
`endif

  // Requester indices wrap 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] nextIdx(input logic [1:0] p);
    nextIdx = (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // First requesting index found searching upward from the pointer, mod 3.
  function automatic logic [1:0] rrPick(input logic [1:0] ptr, input logic [2:0] r);
    logic [1:0] c0, c1, c2;
    c0 = ptr;
    c1 = nextIdx(c0);
    c2 = nextIdx(c1);
    if (r[c0])      rrPick = c0;
    else if (r[c1]) rrPick = c1;
    else            rrPick = c2;
  endfunction

  // Steer the current owner's handshake and pixel fields out of the packed buses.
  always_comb begin
    selReq  = 1'b0;
    selLast = 1'b0;
    selX    = '0;
    selY    = '0;
    selCol  = '0;
    case (owner_q)
      2'd0: begin
        selReq  = bus.req[0];
        selLast = bus.last[0];
        selX    = bus.x_in[0 +: XW];
        selY    = bus.y_in[0 +: YW];
        selCol  = bus.col_in[0 +: CW];
      end
      2'd1: begin
        selReq  = bus.req[1];
        selLast = bus.last[1];
        selX    = bus.x_in[XW +: XW];
        selY    = bus.y_in[YW +: YW];
        selCol  = bus.col_in[CW +: CW];
      end
      2'd2: begin
        selReq  = bus.req[2];
        selLast = bus.last[2];
        selX    = bus.x_in[2*XW +: XW];
        selY    = bus.y_in[2*YW +: YW];
        selCol  = bus.col_in[2*CW +: CW];
      end
      default: ;
    endcase
  end

  assign onScreen = (selX < X_LIMIT) && (selY < Y_LIMIT);

  // The grant is a pure decode of the registered state, so it changes only on clock edges.
  always_comb begin
    gntVec = 3'b000;
    if (state_q == BURST) begin
      case (owner_q)
        2'd0:    gntVec = 3'b001;
        2'd1:    gntVec = 3'b010;
        2'd2:    gntVec = 3'b100;
        default: gntVec = 3'b000;
      endcase
    end
  end

  // Next-state and next-output logic. The clear request is only ever
  // consulted in IDLE, which is why a clear cannot cut into a burst.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    vgaX_d      = vgaX_q;
    vgaY_d      = vgaY_q;
    vgaColour_d = vgaColour_q;
    vgaPlot_d   = 1'b0;
`ifdef PIXEL_ARB_CLEAR_EN
    clearPending_d = clearPending_q;
    clearDone_d    = 1'b0;
    clearColour_d  = clearColour_q;
    clrX_d         = clrX_q;
    clrY_d         = clrY_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef PIXEL_ARB_CLEAR_EN
        if (clearPending_q) begin
          state_d = CLEAR;
        end else
`endif
        if (|bus.req) begin
          owner_d = rrPick(ptr_q, bus.req);
          state_d = BURST;
        end
      end

      BURST: begin
        if (selReq) begin
          vgaX_d      = selX;
          vgaY_d      = selY;
          vgaColour_d = selCol;
          vgaPlot_d   = onScreen;
          if (selLast) begin
            ptr_d   = nextIdx(owner_q);
            state_d = IDLE;
          end
        end
      end

`ifdef PIXEL_ARB_CLEAR_EN
      // Raster walk, x inner and y outer; counters are back at 0 on exit.
      CLEAR: begin
        vgaX_d      = clrX_q;
        vgaY_d      = clrY_q;
        vgaColour_d = clearColour_q;
        vgaPlot_d   = 1'b1;
        if (clrX_q == LAST_X) begin
          clrX_d = '0;
          if (clrY_q == LAST_Y) begin
            clrY_d         = '0;
            clearPending_d = 1'b0;
            clearDone_d    = 1'b1;
            state_d        = IDLE;
          end else begin
            clrY_d = clrY_q + YW'(1);
          end
        end else begin
          clrX_d = clrX_q + XW'(1);
        end
      end
`endif

      default: state_d = IDLE;
    endcase

`ifdef PIXEL_ARB_CLEAR_EN
    if (clear_start_i && !clear_busy_o) begin
      clearPending_d = 1'b1;
      clearColour_d  = clear_colour_i;
    end
`endif
  end

  // State and output registers; reset returns everything to idle at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      owner_q     <= 2'd0;
      ptr_q       <= 2'd0;
      vgaX_q      <= '0;
      vgaY_q      <= '0;
      vgaColour_q <= '0;
      vgaPlot_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      vgaX_q      <= vgaX_d;
      vgaY_q      <= vgaY_d;
      vgaColour_q <= vgaColour_d;
      vgaPlot_q   <= vgaPlot_d;
    end
  end

`ifdef PIXEL_ARB_CLEAR_EN
  // Clear engine registers. clearDone_q keeps clear_busy_o high for the
  // cycle in which the final clear pixel is on the VGA port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clearPending_q <= 1'b0;
      clearDone_q    <= 1'b0;
      clearColour_q  <= '0;
      clrX_q         <= '0;
      clrY_q         <= '0;
    end else begin
      clearPending_q <= clearPending_d;
      clearDone_q    <= clearDone_d;
      clearColour_q  <= clearColour_d;
      clrX_q         <= clrX_d;
      clrY_q         <= clrY_d;
    end
  end

  assign clear_busy_o = clearPending_q | clearDone_q;
`else
  logic unusedClear;
  assign unusedClear  = clear_start_i ^ (^clear_colour_i);
  assign clear_busy_o = 1'b0;
`endif

  assign bus.gnt        = gntVec;
  assign bus.vga_x      = vgaX_q;
  assign bus.vga_y      = vgaY_q;
  assign bus.vga_colour = vgaColour_q;
  assign bus.vga_plot   = vgaPlot_q;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// tb_pixel_write_arbiter
//
// Purpose: self-checking bench for pixel_write_arbiter. A transaction-level
// model (owner index or "none", round-robin pointer, linear clear index)
// predicts gnt, the VGA port and clear_busy every cycle; directed sequences
// pin the model with hand-computed values, then randomized requesters with
// wait states and off-screen pixels exercise arbitration.
// Build option: PIXEL_ARB_CLEAR_EN enables the clear-engine sequences.
module tb_pixel_write_arbiter;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 15;
  localparam int SW = 320;
  localparam int SH = 240;
`ifdef PIXEL_ARB_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clearStart = 1'b0;
  logic [CW-1:0] clearColour = '0;
  logic          clearBusy;

  int testsRun = 0;
  int testsFailed = 0;
  bit modelOn = 1'b0;

  pixel_write_arbiter_if #(.XW(XW), .YW(YW), .CW(CW)) bus();

  pixel_write_arbiter dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .bus            (bus),
    .clear_start_i  (clearStart),
    .clear_colour_i (clearColour),
    .clear_busy_o   (clearBusy)
  );

  always #5 clk = ~clk;

  // Reference model state: owner -1 means no burst, clrIdx -1 means no clear.
  int            mOwner = -1;
  int            mPtr = 0;
  int            mClrIdx = -1;
  int            mC;
  bit            mPending = 1'b0;
  bit            mTail = 1'b0;
  bit            mAccept;
  bit            mFound;
  logic [CW-1:0] mClrCol = '0;
  logic [2:0]    eGnt = '0;
  logic [XW-1:0] eX = '0;
  logic [YW-1:0] eY = '0;
  logic [CW-1:0] eCol = '0;
  bit            ePlot = 1'b0;
  bit            eBusy = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model advances on every clock edge from the inputs that edge sees.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mOwner = -1; mPtr = 0; mClrIdx = -1; mPending = 1'b0; mTail = 1'b0;
      mClrCol = '0; eGnt = '0; eX = '0; eY = '0; eCol = '0; ePlot = 1'b0; eBusy = 1'b0;
    end else begin
      mAccept = CLR_EN && clearStart && !(mPending || mTail);
      ePlot = 1'b0;
      mTail = 1'b0;
      if (mClrIdx >= 0) begin
        eX = XW'(mClrIdx % SW);
        eY = YW'(mClrIdx / SW);
        eCol = mClrCol;
        ePlot = 1'b1;
        if (mClrIdx == SW*SH - 1) begin
          mClrIdx = -1; mPending = 1'b0; mTail = 1'b1;
        end else begin
          mClrIdx++;
        end
      end else if (mOwner < 0) begin
        if (mPending) begin
          mClrIdx = 0;
        end else begin
          mFound = 1'b0;
          for (int k = 0; k < 3; k++) begin
            mC = (mPtr + k) % 3;
            if (!mFound && bus.req[mC]) begin
              mOwner = mC;
              mFound = 1'b1;
            end
          end
        end
      end else if (bus.req[mOwner]) begin
        eX = bus.x_in[mOwner*XW +: XW];
        eY = bus.y_in[mOwner*YW +: YW];
        eCol = bus.col_in[mOwner*CW +: CW];
        ePlot = (int'(eX) < SW) && (int'(eY) < SH);
        if (bus.last[mOwner]) begin
          mPtr = (mOwner + 1) % 3;
          mOwner = -1;
        end
      end
      if (mAccept) begin
        mPending = 1'b1;
        mClrCol = clearColour;
      end
      eGnt = (mOwner >= 0) ? 3'(1 << mOwner) : 3'b000;
      eBusy = mPending || mTail;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (modelOn && rst_n) begin
      checkOutput("model_gnt", 32'(bus.gnt), 32'(eGnt));
      checkOutput("model_plot", 32'(bus.vga_plot), 32'(ePlot));
      checkOutput("model_busy", 32'(clearBusy), 32'(eBusy));
      if (ePlot) begin
        checkOutput("model_x", 32'(bus.vga_x), 32'(eX));
        checkOutput("model_y", 32'(bus.vga_y), 32'(eY));
        checkOutput("model_colour", 32'(bus.vga_colour), 32'(eCol));
      end
    end
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic setPix(input int i, input int px, input int py, input int pc);
    bus.x_in[i*XW +: XW] = XW'(px);
    bus.y_in[i*YW +: YW] = YW'(py);
    bus.col_in[i*CW +: CW] = CW'(pc);
  endtask

  task automatic newPixel(input int i);
    setPix(i, $urandom_range(0, 335), $urandom_range(0, 250), $urandom_range(0, 32767));
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic [2:0] l);
    bus.req = r;
    bus.last = l;
  endtask

  task automatic applyReset();
    applyStimulus(3'b000, 3'b000);
    clearStart = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
    checkOutput({tag, "_plot"}, 32'(bus.vga_plot), 32'd0);
    checkOutput({tag, "_x"}, 32'(bus.vga_x), 32'd0);
    checkOutput({tag, "_y"}, 32'(bus.vga_y), 32'd0);
    checkOutput({tag, "_colour"}, 32'(bus.vga_colour), 32'd0);
    checkOutput({tag, "_busy"}, 32'(clearBusy), 32'd0);
  endtask

  int  rem[3];
  bit  xfer[3];
  bit  allowNew;
  bit  drained;
  int  plots;
  int  lastX, lastY;
  bit  done, sent, found;
  logic [2:0] rrExp [8] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};

  initial begin
    bus.req = '0; bus.last = '0; bus.x_in = '0; bus.y_in = '0; bus.col_in = '0;
    #1;
    applyReset();
    checkAllZero("reset");
    modelOn = 1'b1;

    // Single 4-pixel burst from requester 0, x 10..13, y 5, red.
    setPix(0, 10, 5, 15'h7C00);
    applyStimulus(3'b001, 3'b000);
    tick();
    checkOutput("b1_gnt_first", 32'(bus.gnt), 32'h1);
    for (int p = 0; p < 4; p++) begin
      setPix(0, 10 + p, 5, 15'h7C00);
      bus.last[0] = (p == 3);
      tick();
      checkOutput("b1_plot", 32'(bus.vga_plot), 32'h1);
      checkOutput("b1_x", 32'(bus.vga_x), 32'(10 + p));
    end
    checkOutput("b1_y", 32'(bus.vga_y), 32'd5);
    checkOutput("b1_colour", 32'(bus.vga_colour), 32'h7C00);
    checkOutput("b1_gnt_end", 32'(bus.gnt), 32'h0);
    applyStimulus(3'b000, 3'b000);
    tick();

    // All three requesting with one-pixel bursts: grants 0,1,2,0 every other cycle.
    applyReset();
    applyStimulus(3'b111, 3'b111);
    for (int k = 0; k < 8; k++) begin
      tick();
      checkOutput("rr_gnt", 32'(bus.gnt), 32'(rrExp[k]));
    end
    applyStimulus(3'b000, 3'b000);
    tick();

    // Owner 0 stalls three cycles while requester 1 waits.
    setPix(0, 50, 60, 15'h03E0);
    setPix(1, 70, 80, 15'h001F);
    applyStimulus(3'b001, 3'b000);
    tick();
    checkOutput("ws_gnt_first", 32'(bus.gnt), 32'h1);
    applyStimulus(3'b010, 3'b000);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("ws_gnt_held", 32'(bus.gnt), 32'h1);
      checkOutput("ws_plot_low", 32'(bus.vga_plot), 32'h0);
    end
    applyStimulus(3'b011, 3'b001);
    tick();
    checkOutput("ws_plot_owner", 32'(bus.vga_plot), 32'h1);
    checkOutput("ws_x_owner", 32'(bus.vga_x), 32'd50);
    checkOutput("ws_gnt_idle", 32'(bus.gnt), 32'h0);
    applyStimulus(3'b010, 3'b010);
    tick();
    checkOutput("ws_gnt_r1", 32'(bus.gnt), 32'h2);
    tick();
    checkOutput("ws_x_r1", 32'(bus.vga_x), 32'd70);
    applyStimulus(3'b000, 3'b000);
    tick();

    // Off-screen pixels transfer without plotting.
    setPix(2, 320, 0, 15'h7FFF);
    applyStimulus(3'b100, 3'b000);
    tick();
    checkOutput("off_gnt", 32'(bus.gnt), 32'h4);
    tick();
    checkOutput("off_plot_x320", 32'(bus.vga_plot), 32'h0);
    setPix(2, 0, 240, 15'h7FFF);
    bus.last = 3'b100;
    tick();
    checkOutput("off_plot_y240", 32'(bus.vga_plot), 32'h0);
    checkOutput("off_gnt_end", 32'(bus.gnt), 32'h0);
    applyStimulus(3'b000, 3'b000);
    tick();

    // Randomized requesters with wait states, then drain all bursts.
    for (int i = 0; i < 3; i++) begin rem[i] = 0; xfer[i] = 1'b0; end
    drained = 1'b0;
    for (int c = 0; c < 1500 && !drained; c++) begin
      allowNew = (c < 1200);
      for (int i = 0; i < 3; i++) begin
        if (xfer[i]) begin
          rem[i]--;
          xfer[i] = 1'b0;
          if (rem[i] > 0) newPixel(i);
        end
        if (allowNew && rem[i] == 0 && $urandom_range(0, 3) == 0) begin
          rem[i] = $urandom_range(1, 5);
          newPixel(i);
        end
        if (rem[i] == 0)     bus.req[i] = 1'b0;
        else if (bus.gnt[i]) bus.req[i] = ($urandom_range(0, 3) != 0);
        else                 bus.req[i] = 1'b1;
        bus.last[i] = (rem[i] == 1);
        xfer[i] = bus.req[i] && bus.gnt[i];
      end
      clearStart = !CLR_EN && ($urandom_range(0, 40) == 0);
      clearColour = CW'($urandom_range(0, 32767));
      if (!allowNew && rem[0] == 0 && rem[1] == 0 && rem[2] == 0) drained = 1'b1;
      tick();
    end
    checkOutput("rand_drained", 32'(drained), 32'h1);
    applyStimulus(3'b000, 3'b000);
    clearStart = 1'b0;
    tick();

`ifdef PIXEL_ARB_CLEAR_EN
    // Clear requested mid-burst: burst completes, then a full-screen fill.
    setPix(0, 5, 5, 15'h1234);
    applyStimulus(3'b001, 3'b000);
    tick();
    checkOutput("clr_burst_gnt", 32'(bus.gnt), 32'h1);
    clearStart = 1'b1;
    clearColour = 15'h0000;
    tick();
    clearStart = 1'b0;
    checkOutput("clr_busy_rise", 32'(clearBusy), 32'h1);
    checkOutput("clr_burst_held", 32'(bus.gnt), 32'h1);
    setPix(0, 6, 5, 15'h1234);
    bus.last = 3'b001;
    tick();
    applyStimulus(3'b000, 3'b000);
    checkOutput("clr_burst_end", 32'(bus.gnt), 32'h0);
    plots = 0; lastX = -1; lastY = -1; done = 1'b0; sent = 1'b0;
    for (int c = 0; c < 80000 && !done; c++) begin
      tick();
      clearStart = 1'b0;
      if (!clearBusy) begin
        done = 1'b1;
      end else if (bus.vga_plot) begin
        plots++;
        lastX = int'(bus.vga_x);
        lastY = int'(bus.vga_y);
      end
      if (plots == 1000 && !sent) begin
        clearStart = 1'b1;
        clearColour = 15'h7FFF;
        sent = 1'b1;
      end
    end
    checkOutput("clr_done", 32'(done), 32'h1);
    checkOutput("clr_count", 32'(plots), 32'd76800);
    checkOutput("clr_last_x", 32'(lastX), 32'd319);
    checkOutput("clr_last_y", 32'(lastY), 32'd239);
    checkOutput("clr_final_colour", 32'(bus.vga_colour), 32'h0);

    // Reset lands mid-clear at pixel (100,50).
    clearStart = 1'b1;
    clearColour = 15'h001F;
    tick();
    clearStart = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20000 && !found; c++) begin
      tick();
      if (bus.vga_plot && bus.vga_x == 9'd100 && bus.vga_y == 8'd50) found = 1'b1;
    end
    checkOutput("rstclr_reached", 32'(found), 32'h1);
    #2 rst_n = 1'b0;
    #1 checkAllZero("rstclr");
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("rstclr_idle_busy", 32'(clearBusy), 32'h0);
      checkOutput("rstclr_idle_plot", 32'(bus.vga_plot), 32'h0);
    end
`endif

    modelOn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
